// File: rtl/decode_stage.sv
// Registered RV32I decode stage: a combinational decoder feeding one output
// register slot with valid/ready handshakes on both sides and a flush.

// Pure combinational decode of one instruction word.
module decode_stage_dec #(
  parameter int XLEN              = 32,
  parameter int REG_FILE_DEPTH    = 32,
  parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH)
) (
  input  logic [31:0]                  instr,
  output logic [REG_FILE_ADDR_LEN-1:0] rd,
  output logic [REG_FILE_ADDR_LEN-1:0] rs1,
  output logic [REG_FILE_ADDR_LEN-1:0] rs2,
  output logic [6:0]                   opcode,
  output logic [2:0]                   funct3,
  output logic [6:0]                   funct7,
  output logic [XLEN-1:0]              imm,
  output logic [2:0]                   fmt,
  output logic                         rs1_used,
  output logic                         rs2_used,
  output logic                         rd_we,
  output logic                         illegal
);
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  // 6 bits so a depth of 32 compares correctly against 5-bit raw fields
  localparam logic [5:0] DEPTH6 = 6'(REG_FILE_DEPTH);

  logic [4:0]  rd_raw, rs1_raw, rs2_raw;
  logic        rd_need;
  logic        known;
  logic        bad_reg;
  logic [31:0] imm32;

  assign rd_raw  = instr[11:7];
  assign rs1_raw = instr[19:15];
  assign rs2_raw = instr[24:20];

  // Raw field extraction, independent of format; indices truncated
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = rd_raw[REG_FILE_ADDR_LEN-1:0];
  assign rs1    = rs1_raw[REG_FILE_ADDR_LEN-1:0];
  assign rs2    = rs2_raw[REG_FILE_ADDR_LEN-1:0];

  // Opcode map: format and register usage (rd_need is before the x0 mask)
  always_comb begin
    fmt      = FMT_X;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    rd_need  = 1'b0;
    known    = 1'b1;
    case (instr[6:0])
      7'b0110011: begin fmt = FMT_R; rs1_used = 1'b1; rs2_used = 1'b1; rd_need = 1'b1; end
      7'b0010011,
      7'b0000011,
      7'b1100111,
      7'b1110011: begin fmt = FMT_I; rs1_used = 1'b1; rd_need = 1'b1; end
      7'b0001111: begin fmt = FMT_I; end
      7'b0100011: begin fmt = FMT_S; rs1_used = 1'b1; rs2_used = 1'b1; end
      7'b1100011: begin fmt = FMT_B; rs1_used = 1'b1; rs2_used = 1'b1; end
      7'b0110111,
      7'b0010111: begin fmt = FMT_U; rd_need = 1'b1; end
      7'b1101111: begin fmt = FMT_J; rd_need = 1'b1; end
      default:    known = 1'b0;
    endcase
  end

  // Immediate assembly; instr[31] is always the sign bit
  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'd0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  // Widen to XLEN; replication count stays >= 1 for XLEN == 32
  assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

  // Register bounds only matter for fields the instruction actually reads/writes
  assign bad_reg = (rs1_used && ({1'b0, rs1_raw} >= DEPTH6)) ||
                   (rs2_used && ({1'b0, rs2_raw} >= DEPTH6)) ||
                   (rd_need  && ({1'b0, rd_raw}  >= DEPTH6));

  assign rd_we   = rd_need && (rd_raw != 5'd0);
  assign illegal = (instr[1:0] != 2'b11) || !known || bad_reg;
endmodule

// Top: one-entry registered slot around the decoder.
module decode_stage #(
  parameter int XLEN              = 32,
  parameter int REG_FILE_DEPTH    = 32,
  parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [XLEN-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [REG_FILE_ADDR_LEN-1:0] rd,
  output logic [REG_FILE_ADDR_LEN-1:0] rs1,
  output logic [REG_FILE_ADDR_LEN-1:0] rs2,
  output logic [6:0]                   opcode,
  output logic [2:0]                   funct3,
  output logic [6:0]                   funct7,
  output logic [XLEN-1:0]              imm,
  output logic [2:0]                   fmt,
  output logic                         rs1_used,
  output logic                         rs2_used,
  output logic                         rd_we,
  output logic                         illegal
);
  localparam int STAGES = 1;

  logic [REG_FILE_ADDR_LEN-1:0] d_rd, d_rs1, d_rs2;
  logic [6:0]                   d_opcode, d_funct7;
  logic [2:0]                   d_funct3, d_fmt;
  logic [XLEN-1:0]              d_imm;
  logic                         d_rs1_used, d_rs2_used, d_rd_we, d_illegal;

  // vld_pipe[0] is the load strobe, vld_pipe[STAGES] the held entry's valid
  logic [STAGES:0] vld_pipe;

  decode_stage_dec #(
    .XLEN              (XLEN),
    .REG_FILE_DEPTH    (REG_FILE_DEPTH),
    .REG_FILE_ADDR_LEN (REG_FILE_ADDR_LEN)
  ) u_dec (
    .instr    (in_instr),
    .rd       (d_rd),
    .rs1      (d_rs1),
    .rs2      (d_rs2),
    .opcode   (d_opcode),
    .funct3   (d_funct3),
    .funct7   (d_funct7),
    .imm      (d_imm),
    .fmt      (d_fmt),
    .rs1_used (d_rs1_used),
    .rs2_used (d_rs2_used),
    .rd_we    (d_rd_we),
    .illegal  (d_illegal)
  );

  assign out_valid   = vld_pipe[STAGES];
  assign in_ready    = !out_valid || out_ready;
  assign vld_pipe[0] = in_valid && in_ready && !flush;

  // Valid bit: flush wins, then load, then drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              vld_pipe[STAGES] <= 1'b0;
    else if (flush)          vld_pipe[STAGES] <= 1'b0;
    else if (vld_pipe[0])    vld_pipe[STAGES] <= 1'b1;
    else if (out_ready)      vld_pipe[STAGES] <= 1'b0;
  end

  // Payload only moves on a load, so a stalled entry holds stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc   <= '0;
      rd       <= '0;
      rs1      <= '0;
      rs2      <= '0;
      opcode   <= '0;
      funct3   <= '0;
      funct7   <= '0;
      imm      <= '0;
      fmt      <= '0;
      rs1_used <= 1'b0;
      rs2_used <= 1'b0;
      rd_we    <= 1'b0;
      illegal  <= 1'b0;
    end else if (vld_pipe[0]) begin
      out_pc   <= in_pc;
      rd       <= d_rd;
      rs1      <= d_rs1;
      rs2      <= d_rs2;
      opcode   <= d_opcode;
      funct3   <= d_funct3;
      funct7   <= d_funct7;
      imm      <= d_imm;
      fmt      <= d_fmt;
      rs1_used <= d_rs1_used;
      rs2_used <= d_rs2_used;
      rd_we    <= d_rd_we;
      illegal  <= d_illegal;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: RV32I instance plus an RV32E instance
// sharing the same stimulus.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, imm;
  logic [4:0]  rd, rs1, rs2;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3, fmt;
  logic        rs1_used, rs2_used, rd_we, illegal;

  logic        e_in_ready, e_out_valid;
  logic [31:0] e_out_pc, e_imm;
  logic [3:0]  e_rd, e_rs1, e_rs2;
  logic [6:0]  e_opcode, e_funct7;
  logic [2:0]  e_funct3, e_fmt;
  logic        e_rs1_used, e_rs2_used, e_rd_we, e_illegal;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .REG_FILE_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .imm(imm), .fmt(fmt), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_we(rd_we), .illegal(illegal)
  );

  decode_stage #(.XLEN(32), .REG_FILE_DEPTH(16)) dut_e (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(e_out_valid), .out_ready(out_ready),
    .out_pc(e_out_pc), .rd(e_rd), .rs1(e_rs1), .rs2(e_rs2), .opcode(e_opcode),
    .funct3(e_funct3), .funct7(e_funct7), .imm(e_imm), .fmt(e_fmt),
    .rs1_used(e_rs1_used), .rs2_used(e_rs2_used), .rd_we(e_rd_we), .illegal(e_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;

    // reset state
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fmt", {29'd0, fmt}, 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    #9 rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADDI x1,x0,-1
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h100; out_ready = 1'b1;
    tick();
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_fmt", {29'd0, fmt}, 32'd1);
    chk("addi_rd", {27'd0, rd}, 32'd1);
    chk("addi_rs1", {27'd0, rs1}, 32'd0);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_rd_we", {31'd0, rd_we}, 32'd1);
    chk("addi_rs1_used", {31'd0, rs1_used}, 32'd1);
    chk("addi_rs2_used", {31'd0, rs2_used}, 32'd0);
    chk("addi_illegal", {31'd0, illegal}, 32'd0);
    chk("addi_pc", out_pc, 32'h100);

    // back-to-back stream, one result per cycle
    in_instr = 32'h0020A423; in_pc = 32'h104;
    tick();
    chk("sw_valid", {31'd0, out_valid}, 32'd1);
    chk("sw_fmt", {29'd0, fmt}, 32'd2);
    chk("sw_imm", imm, 32'd8);
    chk("sw_rs1", {27'd0, rs1}, 32'd1);
    chk("sw_rs2", {27'd0, rs2}, 32'd2);
    chk("sw_rd_we", {31'd0, rd_we}, 32'd0);
    chk("sw_pc", out_pc, 32'h104);
    in_instr = 32'hFE000EE3; in_pc = 32'h108;
    tick();
    chk("beq_fmt", {29'd0, fmt}, 32'd3);
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_rs2_used", {31'd0, rs2_used}, 32'd1);
    in_instr = 32'h001000EF; in_pc = 32'h10C;
    tick();
    chk("jal_fmt", {29'd0, fmt}, 32'd5);
    chk("jal_imm", imm, 32'h00000800);
    chk("jal_rd_we", {31'd0, rd_we}, 32'd1);
    in_instr = 32'h123452B7; in_pc = 32'h110;
    tick();
    chk("lui_fmt", {29'd0, fmt}, 32'd4);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_rd", {27'd0, rd}, 32'd5);
    chk("lui_rs1_used", {31'd0, rs1_used}, 32'd0);
    chk("lui_pc", out_pc, 32'h110);

    // drain
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // backpressure: ADDI held 3 cycles while LUI waits
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h200; out_ready = 1'b0;
    tick();
    chk("bp_load_valid", {31'd0, out_valid}, 32'd1);
    in_instr = 32'h123452B7; in_pc = 32'h204;
    #1;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_opcode", {25'd0, opcode}, 32'h13);
      chk("bp_hold_imm", imm, 32'hFFFFFFFF);
      chk("bp_hold_pc", out_pc, 32'h200);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_opcode", {25'd0, opcode}, 32'h37);
    chk("bp_next_imm", imm, 32'h12345000);
    chk("bp_next_pc", out_pc, 32'h204);
    in_valid = 1'b0;
    tick();
    chk("bp_no_dup", {31'd0, out_valid}, 32'd0);

    // flush with a held entry and a same-cycle input
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h300; out_ready = 1'b0;
    tick();
    chk("fl_held", {31'd0, out_valid}, 32'd1);
    flush = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h304;
    tick();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl_dropped", {31'd0, out_valid}, 32'd0);

    // illegal cases
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h400;
    tick();
    chk("zero_valid", {31'd0, out_valid}, 32'd1);
    chk("zero_illegal", {31'd0, illegal}, 32'd1);
    chk("zero_fmt", {29'd0, fmt}, 32'd7);
    chk("zero_rd_we", {31'd0, rd_we}, 32'd0);
    chk("zero_rs1_used", {31'd0, rs1_used}, 32'd0);
    chk("zero_imm", imm, 32'd0);
    in_instr = 32'h00208833;
    tick();
    chk("add16_i_illegal", {31'd0, illegal}, 32'd0);
    chk("add16_i_rd", {27'd0, rd}, 32'd16);
    chk("add16_i_fmt", {29'd0, fmt}, 32'd0);
    chk("add16_e_illegal", {31'd0, e_illegal}, 32'd1);
    chk("add16_e_rd", {28'd0, e_rd}, 32'd0);
    chk("add16_e_valid", {31'd0, e_out_valid}, 32'd1);
    in_instr = 32'h00000013;
    tick();
    chk("nop_illegal", {31'd0, illegal}, 32'd0);
    chk("nop_rd_we", {31'd0, rd_we}, 32'd0);
    chk("nop_fmt", {29'd0, fmt}, 32'd1);
    chk("nop_e_illegal", {31'd0, e_illegal}, 32'd0);

    // asynchronous reset in the middle of a stall
    in_instr = 32'hFFF00093; in_pc = 32'h500; out_ready = 1'b0;
    tick();
    chk("ar_held", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_imm", imm, 32'd0);
    chk("ar_rd", {27'd0, rd}, 32'd0);
    chk("ar_pc", out_pc, 32'd0);
    chk("ar_rd_we", {31'd0, rd_we}, 32'd0);
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
    chk("ar_still_empty", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
